ls_sequencer: RTL and testbench
===============================

LS_SEQUENCER -- requirements
Module: ls_sequencer

Interface
REQ-001 The block SHALL have parameter ALU_ADD, default 4'b0010, ALU operation code for effective-address add.
REQ-002 The block SHALL have parameter MAX_WAIT, default 15, maximum memory wait cycles before timeout (range 1..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request to execute the instruction on instr.
REQ-006 The block SHALL have port instr  input  32  uPower instruction word, sampled when a start is accepted.
REQ-007 The block SHALL have port mem_ready  input  1  data memory has completed the current access.
REQ-008 The block SHALL have port instr_q  output  32  latched instruction driving register-file and immediate fields.
REQ-009 The block SHALL have port alu_op  output  4  ALU operation select.
REQ-010 The block SHALL have port mem_read  output  1  data memory read enable.
REQ-011 The block SHALL have port mem_write  output  1  data memory write enable.
REQ-012 The block SHALL have port reg_write  output  1  register-file write enable.
REQ-013 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 The block SHALL have port illegal  output  1  one-cycle pulse for an unsupported instruction.
REQ-016 The block SHALL have port timeout  output  1  one-cycle pulse for an aborted memory access.

Function
REQ-017 The block SHALL decode ld as instr[31:26]=6'b111010 with instr[1:0]=2'b00, and std as instr[31:26]=6'b111110 with instr[1:0]=2'b00; all other encodings are illegal.
REQ-018 The FSM SHALL have the states IDLE, DECODE, ADDR, MEM, WB, FIN and ERR.
REQ-019 In IDLE, start=1 SHALL latch instr into instr_q and move the FSM to DECODE on the same edge.
REQ-020 A start asserted while busy=1 SHALL be ignored, and instr_q SHALL hold its value.
REQ-021 DECODE SHALL go to ADDR for ld or std, and to ERR otherwise.
REQ-022 ADDR SHALL last one cycle with alu_op=ALU_ADD, then go to MEM.
REQ-023 In MEM, alu_op SHALL equal ALU_ADD, mem_read SHALL be 1 for ld, and mem_write SHALL be 1 for std, all held until MEM is exited.
REQ-024 In MEM, a 4-bit wait counter SHALL clear on MEM entry and increment on each MEM cycle with mem_ready=0.
REQ-025 mem_ready=1 in MEM SHALL take precedence over the timeout: ld goes to WB, std goes to FIN.
REQ-026 If the wait counter equals MAX_WAIT and mem_ready=0, the FSM SHALL go to ERR with the timeout flag set; no register write occurs.
REQ-027 WB SHALL last one cycle with reg_write=1 and alu_op=ALU_ADD, then go to FIN.
REQ-028 FIN SHALL assert done=1 for one cycle, then return to IDLE.
REQ-029 ERR SHALL assert done=1 together with exactly one of illegal or timeout for one cycle, then return to IDLE.
REQ-030 Outside ADDR, MEM and WB, alu_op SHALL be 4'b0000; mem_read, mem_write and reg_write SHALL be 0 outside their own states.
REQ-031 All outputs SHALL be registered or decoded from state only; no output has a combinational path from start or mem_ready.
REQ-032 Latency with mem_ready already high SHALL be: ld, done 5 cycles after the accepting edge; std, done 4 cycles after the accepting edge.
REQ-033 A new start SHALL be accepted in the first IDLE cycle after FIN or ERR, giving back-to-back operation.

Reset
REQ-034 rst=0 SHALL immediately force the state to IDLE, the wait counter and instr_q to 0, alu_op to 4'b0000, and all 1-bit outputs to 0.
REQ-035 Reset asserted mid-operation SHALL abort that operation with no done, no reg_write pulse and no pending memory enable after release.
REQ-036 After rst returns to 1, the block SHALL accept start on the first rising edge.

Verification
REQ-037 Bench case: ld R1,4(R2) (32'hE8220010) with mem_ready=1 -> mem_read high 1 cycle; reg_write high 1 cycle; done 5 cycles after start; alu_op=4'b0010 in ADDR, MEM and WB.
REQ-038 Bench case: std (opcode 6'b111110) with mem_ready low for 3 MEM cycles -> mem_write high 4 cycles; reg_write never set; done pulse.
REQ-039 Bench case: ld with mem_ready held 0 -> timeout and done pulse after 15 wait cycles; reg_write never set; busy low the next cycle.
REQ-040 Bench case: instr=32'h7C000000 -> illegal and done pulse in the cycle after DECODE; no memory or register enables.
REQ-041 Bench case: rst=0 while in MEM -> all outputs 0 asynchronously; after release, a start is accepted and completes normally.
REQ-042 Bench case: start held high through an ld -> exactly one accept per IDLE visit; instr changes during busy are not reflected on instr_q.

Source files
------------

// File: rtl/ls_sequencer.sv
// ls_sequencer -- load/store control sequencer for the uPower ld/std pair.
//
// Accepts one instruction at a time, decodes it, drives the ALU for the
// effective-address add, runs a bounded-wait data-memory access and (for ld)
// a register-file writeback. Completion is reported with a one-cycle done
// pulse, accompanied by illegal or timeout when the operation was aborted.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-low reset
//   start      : request to execute instr (ignored while busy)
//   instr      : instruction word, captured when start is accepted
//   mem_ready  : data memory has completed the current access
//   instr_q    : captured instruction (feeds register/immediate fields)
//   alu_op     : ALU operation select (ALU_ADD in ADDR/MEM/WB, else 0)
//   mem_read   : data memory read enable (ld in MEM)
//   mem_write  : data memory write enable (std in MEM)
//   reg_write  : register-file write enable (WB)
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   illegal    : one-cycle pulse with done for an unsupported encoding
//   timeout    : one-cycle pulse with done for an aborted memory access
module ls_sequencer #(
  parameter logic [3:0]  ALU_ADD  = 4'b0010,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [31:0] instr_q,
  output logic [3:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ADDR   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FIN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] instr_d;
  logic [3:0]  wcnt_q, wcnt_d;
  // Records why ERR was entered; outputs in ERR decode it with the state,
  // so illegal/timeout stay purely state-derived.
  logic        tmo_q, tmo_d;

  logic is_ld, is_std;

  assign is_ld  = (instr_q[31:26] == 6'b111010) && (instr_q[1:0] == 2'b00);
  assign is_std = (instr_q[31:26] == 6'b111110) && (instr_q[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    alu_op    = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_ld || is_std) begin
          state_d = ADDR;
        end else begin
          tmo_d   = 1'b0;
          state_d = ERR;
        end
      end
      ADDR: begin
        alu_op  = ALU_ADD;
        wcnt_d  = '0;
        state_d = MEM;
      end
      MEM: begin
        alu_op    = ALU_ADD;
        mem_read  = is_ld;
        mem_write = is_std;
        // mem_ready wins over the timeout check in the same cycle
        if (mem_ready) begin
          state_d = is_ld ? WB : FIN;
        end else if (wcnt_q == MAX_WAIT_C) begin
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      WB: begin
        alu_op    = ALU_ADD;
        reg_write = 1'b1;
        state_d   = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        illegal = !tmo_q;
        timeout = tmo_q;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ls_sequencer.sv
module tb_ls_sequencer;

  localparam logic [3:0] ALU = 4'b0010;
  localparam int         MW  = 15;

  localparam logic [31:0] LD_I  = 32'hE8220010;
  localparam logic [31:0] STD_I = 32'hF8220010;
  localparam logic [31:0] BAD_I = 32'h7C000000;
  localparam logic [31:0] LDX_I = 32'hE8220011;

  logic        clk, rst, start, mem_ready;
  logic [31:0] instr, instr_q;
  logic [3:0]  alu_op;
  logic        mem_read, mem_write, reg_write, busy, done, illegal, timeout;

  ls_sequencer #(.ALU_ADD(ALU), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .mem_ready(mem_ready),
    .instr_q(instr_q), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .busy(busy), .done(done),
    .illegal(illegal), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ill;
    logic       tmo;
    logic       rd;
    logic       wr;
    logic       rw;
    logic [3:0] alu;
    logic       rdy;  // mem_ready value the bench drives in this cycle
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_instr;
  bit          cur_idle;
  bit          chk_en;
  int          cur_nlow;
  int          acc_cnt;
  int          n_checks, n_err;
  int          cnt_rd, cnt_wr, cnt_rw, cnt_done, cnt_ill, cnt_tmo, busy_run, done_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Expected per-cycle timeline of one accepted instruction, given that the
  // memory keeps mem_ready low for the first nlow MEM cycles.
  function automatic void build(input logic [31:0] ins, input int nlow);
    exp_t e;
    logic ld, sd;
    bit   tmo;
    int   nmem;
    ld = (ins[31:26] == 6'b111010) && (ins[1:0] == 2'b00);
    sd = (ins[31:26] == 6'b111110) && (ins[1:0] == 2'b00);
    e = '0; e.rdy = 1'b1; e.busy = 1'b1;
    exp_q.push_back(e);
    if (!(ld || sd)) begin
      e.done = 1'b1; e.ill = 1'b1;
      exp_q.push_back(e);
      return;
    end
    e.alu = ALU;
    exp_q.push_back(e);
    tmo  = nlow > MW;
    nmem = tmo ? MW + 1 : nlow + 1;
    for (int k = 0; k < nmem; k++) begin
      e.rd = ld; e.wr = sd; e.rdy = (k >= nlow);
      exp_q.push_back(e);
    end
    e.rd = 1'b0; e.wr = 1'b0; e.rdy = 1'b1;
    if (tmo) begin
      e.alu = '0; e.done = 1'b1; e.tmo = 1'b1;
      exp_q.push_back(e);
      return;
    end
    if (ld) begin
      e.rw = 1'b1;
      exp_q.push_back(e);
      e.rw = 1'b0;
    end
    e.alu = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e = '0; e.rdy = 1'b1; end
    cur_idle = !e.busy;
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("timeout", 32'(timeout), 32'(e.tmo));
      chk("mem_read", 32'(mem_read), 32'(e.rd));
      chk("mem_write", 32'(mem_write), 32'(e.wr));
      chk("reg_write", 32'(reg_write), 32'(e.rw));
      chk("alu_op", 32'(alu_op), 32'(e.alu));
      chk("instr_q", instr_q, model_instr);
      cnt_rd   += int'(mem_read);
      cnt_wr   += int'(mem_write);
      cnt_rw   += int'(reg_write);
      cnt_ill  += int'(illegal);
      cnt_tmo  += int'(timeout);
      busy_run  = busy ? busy_run + 1 : 0;
      if (done) begin
        cnt_done++;
        done_at = busy_run;
      end
    end
  end

  // One clock: accept per model, then drive mem_ready for the new cycle.
  task automatic cycle();
    @(posedge clk);
    if (rst && start && cur_idle) begin
      model_instr = instr;
      acc_cnt++;
      build(instr, cur_nlow);
    end
    #1;
    mem_ready = (exp_q.size() > 0) ? exp_q[0].rdy : 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr();
    cnt_rd = 0; cnt_wr = 0; cnt_rw = 0; cnt_done = 0;
    cnt_ill = 0; cnt_tmo = 0; done_at = -1; acc_cnt = 0;
  endtask

  // Single-shot operation: start for one edge, then let it drain.
  task automatic run_op(input logic [31:0] ins, input int nlow, input int drain);
    clr();
    cur_nlow = nlow;
    instr = ins; start = 1'b1;
    cycle();
    start = 1'b0; instr = 32'hDEADBEEF;
    cycles(drain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0; chk_en = 0; cur_idle = 1; busy_run = 0;
    model_instr = '0; cur_nlow = 0;
    clr();
    start = 1'b0; instr = '0; mem_ready = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_en = 1;
    chk("reset_outs", {25'b0, busy, done, illegal, timeout, mem_read, mem_write, reg_write},
        32'h0);
    chk("reset_alu", 32'(alu_op), 32'h0);
    chk("reset_instr_q", instr_q, 32'h0);
    cycles(2);
    // Release and start on the very first edge afterwards.
    rst = 1'b1;
    run_op(LD_I, 0, 7);
    chk("ld_rd_cycles", 32'(cnt_rd), 32'd1);
    chk("ld_rw_cycles", 32'(cnt_rw), 32'd1);
    chk("ld_done_lat", 32'(done_at), 32'd5);

    run_op(STD_I, 3, 10);
    chk("std_wait_wr_cycles", 32'(cnt_wr), 32'd4);
    chk("std_wait_rw", 32'(cnt_rw), 32'd0);
    chk("std_wait_done", 32'(cnt_done), 32'd1);

    run_op(STD_I, 0, 6);
    chk("std_done_lat", 32'(done_at), 32'd4);

    run_op(LD_I, 99, 22);
    chk("tmo_rd_cycles", 32'(cnt_rd), 32'd16);
    chk("tmo_rw", 32'(cnt_rw), 32'd0);
    chk("tmo_pulse", 32'(cnt_tmo), 32'd1);
    chk("tmo_done_lat", 32'(done_at), 32'd19);

    run_op(STD_I, 15, 22);
    chk("ready_last_wait_tmo", 32'(cnt_tmo), 32'd0);
    chk("ready_last_wait_wr", 32'(cnt_wr), 32'd16);

    run_op(STD_I, 16, 22);
    chk("wait16_tmo", 32'(cnt_tmo), 32'd1);

    run_op(BAD_I, 0, 4);
    chk("ill_pulse", 32'(cnt_ill), 32'd1);
    chk("ill_enables", 32'(cnt_rd + cnt_wr + cnt_rw), 32'd0);
    chk("ill_done_lat", 32'(done_at), 32'd2);

    run_op(LDX_I, 0, 4);
    chk("ld_lowbits_ill", 32'(cnt_ill), 32'd1);

    // Asynchronous reset while in MEM.
    clr();
    cur_nlow = 99; instr = LD_I; start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(2);
    #2;
    rst = 1'b0;
    exp_q.delete();
    model_instr = '0;
    #1;
    chk("async_rst_outs", {25'b0, busy, done, illegal, timeout, mem_read, mem_write, reg_write},
        32'h0);
    chk("async_rst_alu", 32'(alu_op), 32'h0);
    chk("async_rst_instr_q", instr_q, 32'h0);
    cycles(2);
    chk("rst_no_done", 32'(cnt_done), 32'd0);
    rst = 1'b1;
    run_op(LD_I, 0, 7);
    chk("post_rst_done_lat", 32'(done_at), 32'd5);
    chk("post_rst_rw", 32'(cnt_rw), 32'd1);

    // start held high: one accept per IDLE visit, instr changes unseen.
    clr();
    cur_nlow = 0; instr = LD_I; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 1) instr = STD_I;
      if (i == 8) instr = STD_I ^ 32'h00FF_0000;
    end
    start = 1'b0;
    cycles(8);
    chk("hold_accepts", 32'(acc_cnt), 32'd3);
    chk("hold_dones", 32'(cnt_done), 32'd3);
    chk("hold_rw", 32'(cnt_rw), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
